// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB pipeline register, the decode-stage read ports and the
// write-back stage of the 32x32 integer register file.
interface wb_regfile_if #(
  parameter int SIZE = 32
);
  logic [4:0]      RD;
  logic [SIZE-1:0] imm_extended;
  logic [SIZE-1:0] ALU_Result;
  logic [SIZE-1:0] pcplus4;
  logic [SIZE-1:0] mem_data;
  logic            regwrite_en;
  logic [1:0]      wb_src;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [SIZE-1:0] rd1;
  logic [SIZE-1:0] rd2;
  logic [SIZE-1:0] wb_data;
  logic            wb_valid;
  logic [31:0]     wb_count;

  modport master (
    output RD, imm_extended, ALU_Result, pcplus4, mem_data, regwrite_en, wb_src, rs1, rs2,
    input  rd1, rd2, wb_data, wb_valid, wb_count
  );

  modport slave (
    input  RD, imm_extended, ALU_Result, pcplus4, mem_data, regwrite_en, wb_src, rs1, rs2,
    output rd1, rd2, wb_data, wb_valid, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects the commit value, writes the flop-based register file,
// serves two bypassed read ports and counts committed writes.
module wb_regfile #(
  parameter int SIZE  = 32,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_MEM = 2'b01,
    SRC_PC4 = 2'b10,
    SRC_IMM = 2'b11
  } wb_src_e;

  logic [SIZE-1:0] regs_q [NREGS];
  logic [SIZE-1:0] regs_d [NREGS];
  logic [31:0]     wb_count_q;
  logic [31:0]     wb_count_d;
  logic [SIZE-1:0] wb_data;
  logic            wb_valid;
  logic [SIZE-1:0] rd1;
  logic [SIZE-1:0] rd2;

  always_comb begin
    wb_data = bus.ALU_Result;
    case (wb_src_e'(bus.wb_src))
      SRC_ALU: wb_data = bus.ALU_Result;
      SRC_MEM: wb_data = bus.mem_data;
      SRC_PC4: wb_data = bus.pcplus4;
      SRC_IMM: wb_data = bus.imm_extended;
      default: wb_data = bus.ALU_Result;
    endcase
  end

  // Writes to x0 never count as commits, so x0 stays hard-wired to zero.
  assign wb_valid = bus.regwrite_en && (bus.RD != 5'd0);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    regs_d = regs_q;
    wb_count_d = wb_count_q;
    if (wb_valid) begin
      regs_d[bus.RD] = wb_data;
      wb_count_d     = wb_count_q + 32'd1;
    end
  end

  // Bypass lets ID see the value committed on this same edge.
  always_comb begin
    rd1 = regs_q[bus.rs1];
    if (bus.rs1 == 5'd0)
      rd1 = '0;
    else if (wb_valid && (bus.rs1 == bus.RD))
      rd1 = wb_data;
  end

  always_comb begin
    rd2 = regs_q[bus.rs2];
    if (bus.rs2 == 5'd0)
      rd2 = '0;
    else if (wb_valid && (bus.rs2 == bus.RD))
      rd2 = wb_data;
  end

  // NOTE: storage is plain flops so the asynchronous clear reaches every entry;
  // sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  assign bus.wb_data  = wb_data;
  assign bus.wb_valid = wb_valid;
  assign bus.rd1      = rd1;
  assign bus.rd2      = rd2;
  assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expected values are queued when stimulus is
// driven and popped against DUT outputs when they become observable.
module tb_wb_regfile;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  logic [31:0] model [32];
  logic [31:0] exp_count;

  wb_regfile_if #(.SIZE(32)) bus ();

  wb_regfile #(.SIZE(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h required=<queued expectation>", observed);
    end else begin
      e = exp_q.pop_front();
      assert (observed === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.val);
      end
    end
  endtask

  task automatic drive_idle();
    bus.RD = 5'd0; bus.regwrite_en = 1'b0; bus.wb_src = 2'b00;
    bus.ALU_Result = '0; bus.mem_data = '0; bus.pcplus4 = '0; bus.imm_extended = '0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
  endtask

  // Commit through the ALU path, updating the bench model.
  task automatic commit_alu(input logic [4:0] rd, input logic [31:0] val);
    @(negedge clk);
    bus.RD = rd; bus.regwrite_en = 1'b1; bus.wb_src = 2'b00; bus.ALU_Result = val;
    if (rd != 5'd0) begin
      model[rd] = val;
      exp_count = exp_count + 32'd1;
    end
    @(posedge clk); #1;
    bus.regwrite_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_count = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    drive_idle();
    rst = 1'b0;

    // Reset state
    #12;
    bus.rs1 = 5'd5; bus.rs2 = 5'd31; #1;
    push("reset_rd1", 32'h0);        check(bus.rd1);
    push("reset_rd2", 32'h0);        check(bus.rd2);
    push("reset_count", 32'h0);      check(bus.wb_count);
    @(negedge clk); rst = 1'b1;

    // Asynchronous reset mid-cycle clears storage and counter without a clock edge
    commit_alu(5'd5, 32'h1234);
    bus.rs1 = 5'd5; #1;
    push("pre_reset_x5", 32'h1234);  check(bus.rd1);
    push("pre_reset_count", 32'h1); check(bus.wb_count);
    #1 rst = 1'b0; #1;
    push("async_reset_x5", 32'h0);   check(bus.rd1);
    push("async_reset_count", 32'h0); check(bus.wb_count);
    model[5] = '0; exp_count = '0;
    @(negedge clk); rst = 1'b1;

    // wb_src sweep on x3
    bus.ALU_Result = 32'hA; bus.mem_data = 32'hB; bus.pcplus4 = 32'hC; bus.imm_extended = 32'hD;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      bus.RD = 5'd3; bus.regwrite_en = 1'b1; bus.wb_src = 2'(s); bus.rs1 = 5'd0;
      push($sformatf("wb_data_src%0d", s), 32'hA + 32'(s));
      push($sformatf("x3_after_src%0d", s), 32'hA + 32'(s));
      model[3] = 32'hA + 32'(s);
      exp_count = exp_count + 32'd1;
      #1 check(bus.wb_data);
      @(posedge clk); #1;
      bus.regwrite_en = 1'b0; bus.rs1 = 5'd3; #1;
      check(bus.rd1);
    end
    push("count_after_sweep", 32'd4); check(bus.wb_count);

    // x0 protection
    @(negedge clk);
    bus.RD = 5'd0; bus.regwrite_en = 1'b1; bus.wb_src = 2'b00; bus.ALU_Result = 32'hFFFF_FFFF; bus.rs1 = 5'd0;
    #1;
    push("x0_same_cycle", 32'h0);    check(bus.rd1);
    push("x0_wb_valid", 32'h0);      check({31'b0, bus.wb_valid});
    @(posedge clk); #1;
    bus.regwrite_en = 1'b0; #1;
    push("x0_next_cycle", 32'h0);    check(bus.rd1);
    push("x0_count", exp_count);     check(bus.wb_count);

    // Bypass on x7, disabled then enabled
    commit_alu(5'd7, 32'h11);
    @(negedge clk);
    bus.RD = 5'd7; bus.regwrite_en = 1'b0; bus.ALU_Result = 32'h22; bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    #1;
    push("nobypass_rd1", 32'h11);    check(bus.rd1);
    push("nobypass_rd2", 32'h11);    check(bus.rd2);
    bus.regwrite_en = 1'b1; #1;
    push("bypass_rd1", 32'h22);      check(bus.rd1);
    push("bypass_rd2", 32'h22);      check(bus.rd2);
    push("bypass_wb_valid", 32'h1);  check({31'b0, bus.wb_valid});
    model[7] = 32'h22; exp_count = exp_count + 32'd1;
    @(posedge clk); #1;
    bus.regwrite_en = 1'b0; #1;
    push("x7_after_commit", 32'h22); check(bus.rd2);

    // Disabled write leaves x9 alone
    commit_alu(5'd9, 32'h99);
    @(negedge clk);
    bus.RD = 5'd9; bus.regwrite_en = 1'b0; bus.ALU_Result = 32'h55; bus.rs1 = 5'd9;
    @(posedge clk); #1;
    push("x9_kept", 32'h99);         check(bus.rd1);
    push("x9_count", exp_count);     check(bus.wb_count);

    // Random commits read back on port B, using the bench model
    for (int k = 0; k < 8; k++) begin
      logic [4:0]  r;
      logic [31:0] v;
      r = 5'($urandom_range(31, 1));
      v = $urandom;
      commit_alu(r, v);
      bus.rs2 = r; #1;
      push($sformatf("rand_x%0d", r), model[r]); check(bus.rd2);
    end
    bus.rs2 = 5'd3; #1;
    push("x3_untouched_or_model", model[3]); check(bus.rd2);
    push("count_after_random", exp_count);   check(bus.wb_count);

    // Counter wrap via hierarchical preset
    @(negedge clk);
    dut.wb_count_q = 32'hFFFF_FFFF;
    exp_count = 32'hFFFF_FFFF;
    #1;
    push("count_preset", exp_count); check(bus.wb_count);
    commit_alu(5'd12, 32'hCAFE);
    push("count_wrap", 32'h0);       check(bus.wb_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the pipeline: consumes the MEM/WB pipeline register outputs and commits results to the 32x32 integer register file.
- Selects the write-back value by wb_src and writes rd on the rising clock edge.
- Serves the two decode-stage read ports, with same-cycle write-through bypass so ID never reads stale data.
- Keeps a count of committed writes for debug and performance monitoring.

Parameters:
SIZE, 32, data width of registers and all data ports
NREGS, 32, number of architectural registers; fixed at 32 (5-bit indices)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
RD  input  5  destination register index from MEM/WB
imm_extended  input  SIZE  immediate from MEM/WB (LUI path)
ALU_Result  input  SIZE  ALU result from MEM/WB
pcplus4  input  SIZE  PC+4 from MEM/WB (JAL/JALR link)
mem_data  input  SIZE  load data from MEM/WB
regwrite_en  input  1  commit enable from MEM/WB
wb_src  input  2  write-back select: 00 ALU_Result, 01 mem_data, 10 pcplus4, 11 imm_extended
rs1  input  5  ID read index A
rs2  input  5  ID read index B
rd1  output  SIZE  read data A
rd2  output  SIZE  read data B
wb_data  output  SIZE  selected write-back value; also routed to the forwarding mux
wb_valid  output  1  high when a real commit happens this cycle
wb_count  output  32  number of committed writes since reset

Behaviour:
- Reset (rst low): takes effect asynchronously, independent of clk.
  - All NREGS registers clear to 0.
  - wb_count clears to 0.
  - Storage and counter stay cleared while rst is held low.
  - On release, the first commit occurs on the first rising edge with rst high.
- wb_data: combinational 4:1 mux on wb_src. Driven every cycle regardless of regwrite_en.
- wb_valid: combinational; equals regwrite_en && (RD != 0).
- Commit: on posedge clk with rst high and wb_valid=1, reg[RD] <= wb_data. Latency 1 cycle.
- x0: any write to index 0 is discarded. Reads of index 0 always return 0, including through the bypass.
- Read ports: combinational, no read latency.
  - rdN = 0 if rsN == 0.
  - Otherwise rdN = wb_data if wb_valid && (rsN == RD) (bypass: the value being written this edge is visible in the same cycle).
  - Otherwise rdN = reg[rsN].
- rs1 == rs2: both ports return identical data, including when both hit the bypass.
- wb_count: increments by 1 on each posedge with wb_valid=1. Wraps 0xFFFFFFFF -> 0 with no flag. Does not increment for RD=0 or regwrite_en=0.
- Reset mid-operation: a commit coincident with rst going low is lost. Asynchronous clear wins.
- X/undefined wb_src is not possible: all 4 encodings are defined.
- Storage is flops, not inferred RAM: the asynchronous clear must apply to every entry.

Test Plan:
- Reset: write x5=0x1234, assert rst low mid-cycle -> rd1 (rs1=5) reads 0 immediately, without waiting for a clock edge; wb_count=0.
- wb_src sweep: RD=3, regwrite_en=1, ALU_Result=0xA, mem_data=0xB, pcplus4=0xC, imm_extended=0xD, wb_src=00/01/10/11 on four cycles -> x3 reads 0xA, 0xB, 0xC, 0xD in turn one cycle after each commit; wb_count=4.
- x0 protection: RD=0, regwrite_en=1, ALU_Result=0xFFFFFFFF -> rs1=0 reads 0 in the same cycle and the next; wb_valid=0; wb_count unchanged.
- Bypass: x7 holds 0x11; commit x7<=0x22 with rs1=rs2=7 -> both rd1 and rd2 show 0x22 in the commit cycle, before the edge. With regwrite_en=0 in the same setup -> both show 0x11.
- Disabled write: regwrite_en=0, RD=9, ALU_Result=0x55 -> x9 keeps its prior value; wb_count unchanged.
- Counter wrap: force wb_count to 0xFFFFFFFF by issuing commits (or via a hierarchical preset), then one more commit -> wb_count=0.
